// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad scanner.
// The decode turns a latched row pattern plus the driven column into a key classification.
package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    PRESS_DB = 3'd1,
    EMIT     = 3'd2,
    WAIT_REL = 3'd3,
    REL_DB   = 3'd4
  } kp_state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hE;  // '*'
  localparam logic [3:0] KEY_HASH  = 4'hF;  // '#'

  // Indexed by {row, col}
  localparam logic [0:15][3:0] KEY_MAP = {
    4'h1,      4'h2, 4'h3,     4'hA,
    4'h4,      4'h5, 4'h6,     4'hB,
    4'h7,      4'h8, 4'h9,     4'hC,
    KEY_CLEAR, 4'h0, KEY_HASH, 4'hD
  };

  typedef struct packed {
    logic       valid;
    logic       is_digit;
    logic       is_clear;
    logic [3:0] value;
  } key_dec_t;

  // valid only when exactly one row is pulled low
  function automatic key_dec_t key_decode(input logic [3:0] rows_n, input logic [1:0] col);
    key_dec_t   d;
    logic [1:0] row;
    logic [2:0] n_low;
    row   = 2'd0;
    n_low = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rows_n[i]) begin
        n_low = n_low + 3'd1;
        row   = i[1:0];
      end
    end
    d.value    = KEY_MAP[{row, col}];
    d.valid    = (n_low == 3'd1);
    d.is_digit = d.valid && (d.value <= 4'd9);
    d.is_clear = d.valid && (d.value == KEY_CLEAR);
    return d;
  endfunction

endpackage

// File: rtl/kp_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs.
// Resets to all-high so an idle keypad is seen during and after reset.
module kp_row_sync (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_row_n,
  output logic [3:0] o_rows_s
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_meta <= 4'b1111;
      r_sync <= 4'b1111;
    end else begin
      r_meta <= i_row_n;
      r_sync <= r_meta;
    end
  end

  assign o_rows_s = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, one-cycle enter/clear strobes.
// Strobes and digit are registered on entry to EMIT so digit is valid with enter.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_row_n,
  output logic [3:0] o_col_n,
  output logic [3:0] o_digit,
  output logic       o_enter,
  output logic       o_clear,
  output logic       o_busy
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);

  logic [3:0]    w_rows_s;
  kp_state_t     r_state, w_state;
  logic [1:0]    r_col,   w_col;
  logic [SW-1:0] r_slot,  w_slot;
  logic [DW-1:0] r_db,    w_db;
  logic [3:0]    r_pat,   w_pat;
  logic [3:0]    r_digit, w_digit;
  logic          r_enter, w_enter;
  logic          r_clear, w_clear;
  logic          r_busy,  w_busy;
  key_dec_t      w_key;

  kp_row_sync u_sync (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_row_n  (i_row_n),
    .o_rows_s (w_rows_s)
  );

  assign w_key = key_decode(r_pat, r_col);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= SCAN;
      r_col   <= 2'd0;
      r_slot  <= '0;
      r_db    <= '0;
      r_pat   <= 4'b1111;
      r_digit <= 4'd0;
      r_enter <= 1'b0;
      r_clear <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_col   <= w_col;
      r_slot  <= w_slot;
      r_db    <= w_db;
      r_pat   <= w_pat;
      r_digit <= w_digit;
      r_enter <= w_enter;
      r_clear <= w_clear;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_col   = r_col;
    w_slot  = r_slot;
    w_db    = r_db;
    w_pat   = r_pat;
    w_digit = r_digit;
    w_enter = 1'b0;
    w_clear = 1'b0;
    w_busy  = r_busy;
    case (r_state)
      SCAN: begin
        if (r_slot == SLOT_LAST) begin
          w_slot = '0;
          if (w_rows_s == 4'b1111) begin
            w_col = r_col + 2'd1;
          end else begin
            w_pat   = w_rows_s;
            w_busy  = 1'b1;
            w_db    = '0;
            w_state = PRESS_DB;
          end
        end else begin
          w_slot = r_slot + 1'b1;
        end
      end
      PRESS_DB: begin
        if (w_rows_s != r_pat) begin
          w_busy  = 1'b0;
          w_col   = r_col + 2'd1;
          w_slot  = '0;
          w_state = SCAN;
        end else if (r_db == DB_LAST) begin
          w_state = EMIT;
          if (w_key.valid && w_key.is_digit) begin
            w_enter = 1'b1;
            w_digit = w_key.value;
          end else if (w_key.valid && w_key.is_clear) begin
            w_clear = 1'b1;
          end
        end else begin
          w_db = r_db + 1'b1;
        end
      end
      EMIT: w_state = WAIT_REL;
      WAIT_REL: begin
        if (w_rows_s == 4'b1111) begin
          w_db    = '0;
          w_state = REL_DB;
        end
      end
      REL_DB: begin
        if (w_rows_s != 4'b1111) begin
          w_state = WAIT_REL;
        end else if (r_db == DB_LAST) begin
          w_busy  = 1'b0;
          w_col   = 2'd0;
          w_slot  = '0;
          w_state = SCAN;
        end else begin
          w_db = r_db + 1'b1;
        end
      end
      default: w_state = SCAN;
    endcase
  end

  assign o_col_n = ~(4'b0001 << r_col);
  assign o_digit = r_digit;
  assign o_enter = r_enter;
  assign o_clear = r_clear;
  assign o_busy  = r_busy;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and debounces it.
- Produces the digit/enter strobe stream that the combination-lock FSM consumes: a 4-bit digit plus a one-cycle enter pulse per accepted key.
- Also produces a one-cycle clear pulse for the '*' key.
- Sits between the board keypad pins and the lock core.

Parameters:
- SCAN_DIV, 1000: clock cycles each column stays driven (column slot length), min 4.
- DEBOUNCE_CYC, 20000: consecutive stable cycles required to accept a press and to accept a release, min 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- row_n  input  4  keypad rows, active-low (external pull-ups), asynchronous to clk
- col_n  output  4  keypad column drive, active-low, one-hot-low
- digit  output  4  last accepted digit 0..9; held stable between pulses
- enter  output  1  one-cycle strobe, digit valid in the same cycle
- clear  output  1  one-cycle strobe on accepted '*' key
- busy  output  1  high from press detect until release accepted

Behaviour:
- Reset asserted (reset=0):
  - col_n=4'b1110 (column 0 driven).
  - digit=0, enter=0, clear=0, busy=0.
  - state=SCAN; column index, slot counter and debounce counter all 0.
- row_n passes through a 2-flop synchronizer before any use. rows_s denotes the synchronized value.
- Key map (row,col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- States:
  - SCAN:
    - Slot counter counts 0..SCAN_DIV-1 with the current column driven.
    - At count SCAN_DIV-1, rows_s is sampled:
      - If rows_s==4'b1111: column index increments mod 4 (wraps 3->0), col_n updates next cycle, counter restarts.
      - Otherwise: latch rows_s as the pattern, hold the column, set busy=1, go to PRESS_DB.
  - PRESS_DB:
    - Each cycle, compare rows_s with the latched pattern.
    - On mismatch: busy=0, resume SCAN at the next column.
    - After DEBOUNCE_CYC consecutive matching cycles: go to EMIT.
  - EMIT (exactly 1 cycle):
    - Single row low and key in 0..9: digit<=value, enter=1 this cycle.
    - Single row low and key '*': clear=1; digit unchanged.
    - '#', A-D, or more than one row low: no strobe.
    - Always proceeds to WAIT_REL.
  - WAIT_REL: column held; go to REL_DB when rows_s==4'b1111.
  - REL_DB:
    - Count DEBOUNCE_CYC consecutive cycles of rows_s==4'b1111; any low row returns to WAIT_REL.
    - On completion: busy=0, go to SCAN with column 0 and counter 0.
- Output rules:
  - enter and clear are never asserted together.
  - Each is asserted for exactly one cycle per physical press; holding a key never repeats.
- Latency: the strobe appears exactly DEBOUNCE_CYC+1 cycles after the SCAN sample that detected the key.
- Keys in other columns pressed while a key is held are ignored until the release is accepted.
- Reset mid-operation aborts immediately; no strobe is issued after reset release until a full new press is accepted.
- Counters must be sized with $clog2 of their parameter. No counter wraps except the column index.

Decomposition:
- Shared package keypad_pkg:
  - state encoding (SCAN, PRESS_DB, EMIT, WAIT_REL, REL_DB)
  - key-map constants
  - KEY_CLEAR code
  - key-decode function (row pattern, column) -> {valid, is_digit, is_clear, value}
- One sub-module: kp_row_sync, the 4-bit 2-flop synchronizer with reset value 4'b1111.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8):
- Reset low for 3 cycles, then release, no key -> col_n cycles 1110, 1101, 1011, 0111, 1110, each for 4 cycles; enter=clear=busy=0 throughout.
- Hold key '7' (row2 low when col0 driven) for 40 cycles -> exactly one enter pulse with digit=7, 9 cycles after the detect sample; busy falls 8 cycles after release.
- Press sequence 9,9,7,9 with releases -> four enter pulses carrying digits 9,9,7,9 in order; the lock core downstream reaches unlocked.
- Key '5' bouncing (row1 toggling every 3 cycles for 12 cycles, then stable) -> no pulse during bounce; one enter with digit=5 after 8 stable cycles.
- Press '*' -> clear pulse for 1 cycle, enter=0, digit keeps previous value. Press '#' or 'A' -> no pulse, busy still cycles.
- Rows 0 and 1 both low in col1 (2 and 5) -> no strobe. Reset asserted during PRESS_DB -> outputs return to reset values immediately, no pulse afterwards.
